// File: rtl/muldiv_arb_if.sv
// Bundle of requester, response and muldiv-side signals around muldiv_arb.
// slave is the arbiter's view; master is the view of everything around it.
interface muldiv_arb_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]    kill;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_data;
  logic                  stall;
  logic                  md_valid;
  logic                  md_ready;
  logic [2:0]            md_op;
  logic [31:0]           md_op1;
  logic [31:0]           md_op2;
  logic [31:0]           md_out;
  logic                  md_stall;
  logic                  busy;

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, kill, rsp_ready, stall,
           md_ready, md_out,
    output req_ready, rsp_valid, rsp_data, md_valid, md_op, md_op1, md_op2,
           md_stall, busy
  );

  modport master (
    output req_valid, req_op, req_op1, req_op2, kill, rsp_ready, stall,
           md_ready, md_out,
    input  req_ready, rsp_valid, rsp_data, md_valid, md_op, md_op1, md_op2,
           md_stall, busy
  );
endinterface

// File: rtl/muldiv_arb.sv
// Round-robin arbiter sharing one multi-cycle muldiv unit between NUM_REQ
// requesters; holds operands through the op and returns the result by valid/ready.
module muldiv_arb #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_arb_if.slave   bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]         state_q,    state_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic               drop_q,     drop_d;
  logic [2:0]         op_q,       op_d;
  logic [31:0]        op1_q,      op1_d;
  logic [31:0]        op2_q,      op2_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] req_ready_c;

  // Round-robin pick: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    elig        = bus.req_valid & ~bus.kill;
    scan_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (elig[scan_idx]) begin
        grant_idx   = scan_idx;
        grant_found = 1'b1;
      end
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    op_d        = op_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rsp_data_d  = rsp_data_q;
    req_ready_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.stall && grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          op_d     = bus.req_op[int'(grant_idx)*3 +: 3];
          op1_d    = bus.req_op1[int'(grant_idx)*32 +: 32];
          op2_d    = bus.req_op2[int'(grant_idx)*32 +: 32];
          owner_d  = grant_idx;
          drop_d   = 1'b0;
          rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A kill never aborts the muldiv; it only marks the result for discard.
        if (bus.kill[owner_q]) begin
          drop_d = 1'b1;
        end
        if (bus.md_ready) begin
          rsp_data_d = bus.md_out;
          state_d    = (drop_q || bus.kill[owner_q]) ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.kill[owner_q] || bus.rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      drop_q     <= 1'b0;
      op_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      op_q       <= op_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.md_valid  = (state_q == ST_ISSUE);
  assign bus.md_op     = op_q;
  assign bus.md_op1    = op1_q;
  assign bus.md_op2    = op2_q;
  assign bus.md_stall  = bus.stall;
  assign bus.rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_arb.sv
// Randomized + directed bench for muldiv_arb against a transaction-level model
// with a behavioural RV32M muldiv peer of random latency.
module tb_muldiv_arb;
  localparam int N = 3;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_arb_if #(.NUM_REQ(N)) bus ();
  muldiv_arb #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // Staged inputs, applied at the next falling edge.
  logic [N-1:0] s_kill = '0;
  logic [N-1:0] s_rsp_ready = '0;
  logic         s_stall = 1'b0;
  int           force_lat = 0;

  // Requesters.
  op_t         req_q [N][$];
  op_t         cur [N];
  bit          pend [N];
  bit          waitr [N];
  int          grant_cnt [N];
  int          rsp_cnt [N];
  logic [31:0] last_rsp [N];
  int          drop_cnt = 0;

  // Transaction-level expectation: 0 idle, 1 op outstanding at muldiv, 2 result offered.
  int          m_st = 0;
  int          m_owner = 0;
  int          m_rr = 0;
  bit          m_drop = 0;
  op_t         m_cap;
  logic [31:0] m_res = '0;

  bit md_busy = 0;
  int md_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] rv32m(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (m_st == 0);
    for (int i = 0; i < N; i++)
      if (pend[i] || waitr[i] || req_q[i].size() != 0) r = 0;
    return r;
  endfunction

  task automatic push(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t t;
    t.op = op; t.a = a; t.b = b;
    req_q[i].push_back(t);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {bus.busy, bus.md_valid, bus.rsp_valid, bus.req_ready}, '0);
    chk({tag, "_md"}, {bus.md_op, bus.md_op1, bus.md_op2}, '0);
    chk({tag, "_rsp_data"}, bus.rsp_data, '0);
  endtask

  task automatic model_reset();
    m_st = 0; m_rr = 0; m_drop = 0; m_owner = 0;
    md_busy = 0;
    bus.md_ready = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; waitr[i] = 0; req_q[i].delete();
    end
  endtask

  // One clock: drive at the falling edge, check and advance the model 1ns later.
  task automatic step();
    int win;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && !waitr[i] && req_q[i].size() != 0) begin
        cur[i] = req_q[i].pop_front();
        pend[i] = 1;
      end
      bus.req_valid[i]        = pend[i];
      bus.req_op[3*i +: 3]    = cur[i].op;
      bus.req_op1[32*i +: 32] = cur[i].a;
      bus.req_op2[32*i +: 32] = cur[i].b;
    end
    bus.kill = s_kill;
    bus.rsp_ready = s_rsp_ready;
    bus.stall = s_stall;

    // Muldiv peer: one-cycle result pulse after a latency that stall extends.
    if (rst) begin
      bus.md_ready = 1'b0;
      md_busy = 0;
    end else if (bus.md_ready) begin
      bus.md_ready = 1'b0;
      bus.md_out = $urandom();
    end else if (bus.md_valid) begin
      if (!md_busy) begin
        md_busy = 1;
        md_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
      end
      if (!s_stall) md_cnt--;
      if (md_cnt == 0) begin
        bus.md_ready = 1'b1;
        bus.md_out = rv32m(bus.md_op, bus.md_op1, bus.md_op2);
        md_busy = 0;
      end else begin
        bus.md_out = $urandom();
      end
    end else begin
      bus.md_out = $urandom();
    end
    #1;
    if (rst) begin
      chk_reset("in_reset");
      return;
    end

    win = -1;
    if (m_st == 0 && !s_stall)
      for (int k = 0; k < N; k++)
        if (win < 0 && pend[(m_rr + k) % N] && !s_kill[(m_rr + k) % N]) win = (m_rr + k) % N;

    chk("req_ready", bus.req_ready, (win >= 0) ? (1 << win) : 0);
    chk("busy", bus.busy, m_st != 0);
    chk("md_valid", bus.md_valid, m_st == 1);
    chk("md_stall", bus.md_stall, s_stall);
    chk("rsp_valid", bus.rsp_valid, (m_st == 2) ? (1 << m_owner) : 0);
    if (m_st == 1) chk("md_operands", {bus.md_op, bus.md_op1, bus.md_op2}, {m_cap.op, m_cap.a, m_cap.b});
    if (m_st == 2) chk("rsp_data", bus.rsp_data, m_res);

    case (m_st)
      0: if (win >= 0) begin
           m_cap = cur[win]; m_owner = win; m_drop = 0; m_rr = (win + 1) % N; m_st = 1;
           pend[win] = 0; waitr[win] = 1; grant_cnt[win]++;
         end
      1: begin
           if (s_kill[m_owner]) m_drop = 1;
           if (bus.md_ready) begin
             m_res = rv32m(m_cap.op, m_cap.a, m_cap.b);
             if (m_drop) begin
               m_st = 0; waitr[m_owner] = 0; drop_cnt++;
             end else begin
               m_st = 2;
             end
           end
         end
      default: begin
           if (s_kill[m_owner]) begin
             m_st = 0; waitr[m_owner] = 0; drop_cnt++;
           end else if (s_rsp_ready[m_owner]) begin
             m_st = 0; waitr[m_owner] = 0; rsp_cnt[m_owner]++;
             last_rsp[m_owner] = bus.rsp_data;
           end
         end
    endcase
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (!all_idle() && c < 500) begin step(); c++; end
    chk(tag, all_idle(), 1'b1);
  endtask

  task automatic wait_st(input int st, input string tag);
    int c = 0;
    while (m_st != st && c < 200) begin step(); c++; end
    chk(tag, m_st == st, 1'b1);
  endtask

  initial begin
    int g0, r1, d0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_op1 = '0; bus.req_op2 = '0;
    bus.kill = '0; bus.rsp_ready = '0; bus.stall = 1'b0;
    bus.md_ready = 1'b0; bus.md_out = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; waitr[i] = 0; grant_cnt[i] = 0; rsp_cnt[i] = 0; last_rsp[i] = '0; cur[i] = '0;
    end
    m_cap = '0;
    #1;
    chk_reset("reset");
    step(); step();
    rst = 1'b0;
    s_rsp_ready = '1;

    // MUL 6*7
    push(0, 3'd0, 32'd6, 32'd7);
    drain("drain_mul");
    chk("mul_6x7", last_rsp[0], 32'h0000_002A);

    // Simultaneous MULH and DIV, then fairness over 8 rounds
    push(0, 3'd1, 32'hFFFF_FFFF, 32'd2);
    push(1, 3'd4, 32'd100, 32'd7);
    drain("drain_pair");
    chk("mulh_neg1x2", last_rsp[0], 32'hFFFF_FFFF);
    chk("div_100_7", last_rsp[1], 32'd14);
    g0 = grant_cnt[0]; r1 = grant_cnt[1];
    for (int r = 0; r < 8; r++) begin
      push(0, 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
      push(1, 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
    end
    drain("drain_fair");
    chk("fair_grants0", grant_cnt[0] - g0, 8);
    chk("fair_grants1", grant_cnt[1] - r1, 8);

    // Kill of the owner mid-operation
    force_lat = 6;
    r1 = rsp_cnt[1]; d0 = drop_cnt;
    push(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_st(1, "kill_reach_issue");
    step();
    s_kill = 3'b010;
    step();
    s_kill = '0;
    step();
    chk("kill_md_valid_held", bus.md_valid, 1'b1);
    drain("drain_kill");
    chk("kill_no_rsp", rsp_cnt[1], r1);
    chk("kill_dropped", drop_cnt, d0 + 1);
    force_lat = 0;
    push(1, 3'd0, 32'd7, 32'd8);
    drain("drain_after_kill");
    chk("mul_after_kill", last_rsp[1], 32'd56);

    // Backpressure then kill in the response phase
    s_rsp_ready = '0;
    d0 = drop_cnt; r1 = rsp_cnt[0];
    push(0, 3'd7, 32'd17, 32'd5);
    wait_st(2, "bp_reach_resp");
    repeat (10) step();
    chk("remu_held", bus.rsp_data, 32'd2);
    s_kill = 3'b001;
    step();
    s_kill = '0;
    step();
    chk("resp_kill_drop", drop_cnt, d0 + 1);
    chk("resp_kill_no_rsp", rsp_cnt[0], r1);
    s_rsp_ready = '1;

    // Stall blocks grants, then stretches the muldiv latency
    s_stall = 1'b1;
    g0 = grant_cnt[0];
    push(0, 3'd0, 32'd5, 32'd5);
    repeat (5) step();
    chk("stall_no_grant", grant_cnt[0], g0);
    s_stall = 1'b0;
    force_lat = 2;
    wait_st(1, "stall_reach_issue");
    s_stall = 1'b1;
    repeat (6) step();
    chk("stall_extends", bus.md_valid, 1'b1);
    s_stall = 1'b0;
    drain("drain_stall");
    chk("mul_5x5", last_rsp[0], 32'd25);

    // Asynchronous reset in the middle of an operation
    force_lat = 8;
    push(1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_st(1, "rst_reach_issue");
    step();
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    model_reset();
    step(); step();
    rst = 1'b0;
    force_lat = 0;
    push(0, 3'd0, 32'd3, 32'hFFFF_FFFC);
    drain("drain_after_rst");
    chk("mul_3xm4", last_rsp[0], 32'hFFFF_FFF4);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (req_q[i].size() < 2 && $urandom_range(0, 7) == 0)
          push(i, 3'($urandom_range(0, 7)), rnd_word(), rnd_word());
      s_stall = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) s_kill[i] = ($urandom_range(0, 39) == 0);
      s_rsp_ready = N'($urandom());
      step();
    end
    s_stall = 1'b0; s_kill = '0; s_rsp_ready = '1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
